dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port-per-direction data memory (`d_mem`) between the `rv32i` core (requester 0) and a second master such as a loader, debug or DMA engine (requester 1). It sits between the requesters and `d_mem`. It grants one access per cycle, with fixed priority to requester 0, a starvation limit for requester 1, and an optional lock for multi-cycle ownership. Read data returns one cycle after grant, tagged with a per-requester valid.

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/dmem_arb_starve_cnt.sv | 33 +++
 rtl/dmem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared owner-state encoding, access-size codes and defaults for the d_mem arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_e;

    localparam logic [1:0] MODE_BYTE = 2'd0;
    localparam logic [1:0] MODE_HALF = 2'd1;
    localparam logic [1:0] MODE_WORD = 2'd2;

    localparam int unsigned DEF_STARVE_LIM = 4;
    localparam int unsigned STARVE_CNT_W   = 4;

    // Step toward lim and stick there.
    function automatic logic [STARVE_CNT_W-1:0] sat_inc(
        input logic [STARVE_CNT_W-1:0] v,
        input logic [STARVE_CNT_W-1:0] lim
    );
        if (v >= lim) begin
            return lim;
        end else begin
            return v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive requester-0 wins while requester 1 waits.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned LIM = DEF_STARVE_LIM
) (
    input  logic clk,
    input  logic n_rst,
    input  logic inc,
    input  logic clr,
    output logic at_lim
);

    localparam logic [STARVE_CNT_W-1:0] LIM_C = STARVE_CNT_W'(LIM);

    logic [STARVE_CNT_W-1:0] cnt_r;

    // Clear wins over increment; increment saturates at the limit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r <= 4'd0;
        end else if (clr) begin
            cnt_r <= 4'd0;
        end else if (inc) begin
            cnt_r <= sat_inc(cnt_r, LIM_C);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_lim = (cnt_r == LIM_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester d_mem arbiter: fixed priority to r0, starvation relief and lock for r1.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [1:0]            r0_mode,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_W-1:0]     r0_wdata,
    input  logic                  r0_lock,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [1:0]            r1_mode,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_W-1:0]     r1_wdata,
    input  logic                  r1_lock,
    output logic                  r0_gnt,
    output logic                  r1_gnt,
    output logic                  r0_rvalid,
    output logic                  r1_rvalid,
    output logic [DATA_W-1:0]     r0_rdata,
    output logic [DATA_W-1:0]     r1_rdata,
    output logic                  m_wr_en,
    output logic [1:0]            m_mode,
    output logic [ADDR_WIDTH-1:0] m_wr_addr,
    output logic [ADDR_WIDTH-1:0] m_rd_addr,
    output logic [DATA_W-1:0]     m_d_in,
    input  logic [DATA_W-1:0]     m_d_out
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_conflicts,
    output logic [15:0]           stat_r1_grants
`endif
);

    own_state_e state_r;
    own_state_e state_nxt_s;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       at_lim_s;
    logic       cnt_inc_s;
    logic       cnt_clr_s;
    logic       tag_valid_r;
    logic       tag_owner_r;

    // Grant decision from ownership, priority and starvation state.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!n_rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    if (r1_req && (!r0_req || at_lim_s)) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = r0_req;
                    end
                end
                OWN0:    gnt0_s = r0_req;
                OWN1:    gnt1_s = r1_req;
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Lock holds ownership until an unlocked access or a dropped request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FREE: begin
                if (gnt0_s && r0_lock) begin
                    state_nxt_s = OWN0;
                end else if (gnt1_s && r1_lock) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = FREE;
                end
            end
            OWN0: begin
                if (!r0_req || !r0_lock) begin
                    state_nxt_s = FREE;
                end else begin
                    state_nxt_s = OWN0;
                end
            end
            OWN1: begin
                if (!r1_req || !r1_lock) begin
                    state_nxt_s = FREE;
                end else begin
                    state_nxt_s = OWN1;
                end
            end
            default: state_nxt_s = FREE;
        endcase
    end

    // Ownership state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= FREE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // A locked r0 owner is never preempted, so its grants do not count.
    assign cnt_inc_s = gnt0_s && r1_req && (state_r != OWN0);
    assign cnt_clr_s = gnt1_s || !r1_req;

    dmem_arb_starve_cnt #(
        .LIM (STARVE_LIM)
    ) u_starve_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .inc    (cnt_inc_s),
        .clr    (cnt_clr_s),
        .at_lim (at_lim_s)
    );

    // Route the winner's access to d_mem; idle bus is all zeros.
    always_comb begin
        m_wr_en   = 1'b0;
        m_mode    = MODE_BYTE;
        m_wr_addr = {ADDR_WIDTH{1'b0}};
        m_d_in    = {DATA_W{1'b0}};
        if (gnt0_s) begin
            m_wr_en   = r0_we;
            m_mode    = r0_mode;
            m_wr_addr = r0_addr;
            m_d_in    = r0_wdata;
        end else if (gnt1_s) begin
            m_wr_en   = r1_we;
            m_mode    = r1_mode;
            m_wr_addr = r1_addr;
            m_d_in    = r1_wdata;
        end else begin
            m_wr_en   = 1'b0;
            m_mode    = MODE_BYTE;
            m_wr_addr = {ADDR_WIDTH{1'b0}};
            m_d_in    = {DATA_W{1'b0}};
        end
    end

    assign m_rd_addr = m_wr_addr;
    assign r0_gnt    = gnt0_s;
    assign r1_gnt    = gnt1_s;

    // Read tag follows d_mem's one-cycle registered read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tag_valid_r <= 1'b0;
            tag_owner_r <= 1'b0;
        end else begin
            tag_valid_r <= (gnt0_s && !r0_we) || (gnt1_s && !r1_we);
            tag_owner_r <= gnt1_s;
        end
    end

    assign r0_rvalid = tag_valid_r && !tag_owner_r;
    assign r1_rvalid = tag_valid_r && tag_owner_r;
    assign r0_rdata  = r0_rvalid ? m_d_out : {DATA_W{1'b0}};
    assign r1_rdata  = r1_rvalid ? m_d_out : {DATA_W{1'b0}};

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conf_r;
    logic [15:0] r1g_r;

    // Saturating conflict and requester-1 grant counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            conf_r <= 16'd0;
            r1g_r  <= 16'd0;
        end else begin
            if (r0_req && r1_req && (conf_r != 16'hFFFF)) begin
                conf_r <= conf_r + 16'd1;
            end else begin
                conf_r <= conf_r;
            end
            if (gnt1_s && (r1g_r != 16'hFFFF)) begin
                r1g_r <= r1g_r + 16'd1;
            end else begin
                r1g_r <= r1g_r;
            end
        end
    end

    assign stat_conflicts = conf_r;
    assign stat_r1_grants = r1g_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: reference model predicts grants, bus drive and read returns.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [1:0]    r0_mode, r1_mode;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          m_wr_en;
    logic [1:0]    m_mode;
    logic [AW-1:0] m_wr_addr, m_rd_addr;
    logic [DW-1:0] m_d_in, m_d_out;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_conflicts, stat_r1_grants;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mem_ready = 1'b0;

    typedef struct {
        int            due;
        bit            who;
        logic [DW-1:0] data;
    } rd_t;
    rd_t rq[$];

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .n_rst(n_rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_mode(r0_mode), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_lock(r0_lock),
        .r1_req(r1_req), .r1_we(r1_we), .r1_mode(r1_mode), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_lock(r1_lock),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .m_wr_en(m_wr_en), .m_mode(m_mode), .m_wr_addr(m_wr_addr), .m_rd_addr(m_rd_addr),
        .m_d_in(m_d_in), .m_d_out(m_d_out)
`ifdef DMEM_ARB_STATS_EN
        , .stat_conflicts(stat_conflicts), .stat_r1_grants(stat_r1_grants)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hA500_0000 ^ (a * 32'h0001_0203);
    endfunction

    // d_mem stand-in: one word per address, registered read.
    logic [DW-1:0] env_mem [256];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
        end else if (m_wr_en) begin
            env_mem[m_wr_addr] <= m_d_in;
        end
        m_d_out <= env_mem[m_rd_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic req, input logic we, input logic lock, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd);
        r0_req = req; r0_we = we; r0_lock = lock; r0_mode = MODE_WORD; r0_addr = addr; r0_wdata = wd;
    endtask

    task automatic set1(input logic req, input logic we, input logic lock, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd);
        r1_req = req; r1_we = we; r1_lock = lock; r1_mode = MODE_WORD; r1_addr = addr; r1_wdata = wd;
    endtask

    // Reference model: arbitration rules with integer owner/count and a shadow memory.
    initial begin : model
        logic [DW-1:0] ref_mem [256];
        int            owner;
        int            starve;
        int            e_conf;
        int            e_r1g;
        logic          e0, e1;
        logic [50:0]   e_m;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        owner = -1; starve = 0; e_conf = 0; e_r1g = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                owner = -1; starve = 0; e_conf = 0; e_r1g = 0;
                chk("rst_gnt", {r0_gnt, r1_gnt}, 2'b00);
                chk("rst_mdrv", {m_wr_en, m_mode, m_wr_addr, m_rd_addr, m_d_in}, 64'd0);
`ifdef DMEM_ARB_STATS_EN
                chk("rst_stats", {stat_conflicts, stat_r1_grants}, 64'd0);
`endif
            end else begin
                if (owner == 0) begin
                    e0 = r0_req; e1 = 1'b0;
                end else if (owner == 1) begin
                    e0 = 1'b0; e1 = r1_req;
                end else if (r0_req && r1_req) begin
                    e1 = (starve == LIM); e0 = !e1;
                end else begin
                    e0 = r0_req; e1 = r1_req;
                end
                chk("gnt", {r0_gnt, r1_gnt}, {e0, e1});
                if (e0)      e_m = {r0_we, r0_mode, r0_addr, r0_addr, r0_wdata};
                else if (e1) e_m = {r1_we, r1_mode, r1_addr, r1_addr, r1_wdata};
                else         e_m = 51'd0;
                chk("mdrv", {m_wr_en, m_mode, m_wr_addr, m_rd_addr, m_d_in}, e_m);
`ifdef DMEM_ARB_STATS_EN
                chk("stats", {stat_conflicts, stat_r1_grants}, {e_conf[15:0], e_r1g[15:0]});
                if (r0_req && r1_req && e_conf < 65535) e_conf++;
                if (e1 && e_r1g < 65535) e_r1g++;
`endif
                if (e0 && !r0_we) rq.push_back('{cyc + 1, 1'b0, ref_mem[r0_addr]});
                if (e1 && !r1_we) rq.push_back('{cyc + 1, 1'b1, ref_mem[r1_addr]});
                if (e0 && r0_we) ref_mem[r0_addr] = r0_wdata;
                if (e1 && r1_we) ref_mem[r1_addr] = r1_wdata;
                if (e1 || !r1_req) starve = 0;
                else if (e0 && owner != 0 && starve < LIM) starve++;
                if (owner == 0)           owner = (r0_req && r0_lock) ? 0 : -1;
                else if (owner == 1)      owner = (r1_req && r1_lock) ? 1 : -1;
                else if (e0 && r0_lock)   owner = 0;
                else if (e1 && r1_lock)   owner = 1;
            end
        end
    end

    // Monitor: pops the read expected this cycle and checks both return ports.
    initial begin : monitor
        rd_t it;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                rq.delete();
                chk("rst_rv", {r0_rvalid, r1_rvalid}, 2'b00);
                chk("rst_rdata", {r0_rdata, r1_rdata}, 64'd0);
            end else if (rq.size() > 0 && rq[0].due == cyc) begin
                it = rq.pop_front();
                chk("rvalid", {r0_rvalid, r1_rvalid}, it.who ? 2'b01 : 2'b10);
                chk("rdata", it.who ? r1_rdata : r0_rdata, it.data);
                chk("rdata_idle", it.who ? r0_rdata : r1_rdata, 64'd0);
            end else begin
                chk("no_rv", {r0_rvalid, r1_rvalid}, 2'b00);
                chk("no_rdata", {r0_rdata, r1_rdata}, 64'd0);
            end
        end
    end

    initial begin : stim
        logic [9:0] g1_seq;
        logic [8:0] g0_seq;
        // Reset held with both requesters active.
        n_rst = 1'b0;
        set0(1'b1, 1'b0, 1'b0, 8'h04, 32'h0);
        set1(1'b1, 1'b1, 1'b0, 8'h08, 32'h1111_1111);
        repeat (3) tick();
        mem_ready = 1'b1;
        n_rst = 1'b1;
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        @(negedge clk);
        chk("rel_r1_gnt", r1_gnt, 1'b1);
        tick();
        // r0 write then read back.
        set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set0(1'b1, 1'b1, 1'b0, 8'h10, 32'hDEAD_BEEF);
        tick();
        set0(1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
        tick();
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("wr_rd_rv", {r0_rvalid, r1_rvalid}, 2'b10);
        chk("wr_rd_data", r0_rdata, 32'hDEAD_BEEF);
        tick();
        // Short reset so the conflict run starts from zero statistics.
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g1_seq[i] = r1_gnt;
            tick();
        end
        chk("starve_seq", g1_seq, 10'b10_0001_0000);
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_conflicts", stat_conflicts, 16'd10);
        chk("stat_r1_grants", stat_r1_grants, 16'd2);
`endif
        tick();
        // r1 wins at the starvation limit with lock, keeps ownership, then r0 resumes.
        for (int i = 0; i < 9; i++) begin
            set0(1'b1, 1'b0, 1'b0, 8'(8'h30 + i), 32'h0);
            set1(i < 8, 1'b1, i < 7, 8'(8'h40 + i), $urandom);
            @(negedge clk);
            g0_seq[i] = r0_gnt;
            tick();
        end
        chk("lock_seq", g0_seq, 9'b1_0000_1111);
        // Reset right after a locked r0 read: no rvalid, ownership lost.
        set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set0(1'b1, 1'b0, 1'b1, 8'h10, 32'h0);
        tick();
        n_rst = 1'b0;
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("rst_mid_rv", {r0_rvalid, r1_rvalid}, 2'b00);
        tick();
        tick();
        n_rst = 1'b1;
        set1(1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        @(negedge clk);
        chk("free_after_rst", {r0_gnt, r1_gnt}, 2'b01);
        tick();
        // Randomised traffic on a small address window.
        for (int i = 0; i < 800; i++) begin
            n_rst    = ($urandom_range(63) != 0);
            r0_req   = ($urandom_range(3) != 0);
            r0_we    = $urandom_range(1);
            r0_lock  = ($urandom_range(3) == 0);
            r0_mode  = 2'($urandom_range(2));
            r0_addr  = 8'($urandom_range(15));
            r0_wdata = $urandom;
            r1_req   = ($urandom_range(2) != 0);
            r1_we    = $urandom_range(1);
            r1_lock  = ($urandom_range(2) == 0);
            r1_mode  = 2'($urandom_range(2));
            r1_addr  = 8'($urandom_range(15));
            r1_wdata = $urandom;
            tick();
        end
        n_rst = 1'b1;
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) tick();
        chk("drain", rq.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
